// File: rtl/bus_ctl_pkg.sv
// Shared types and default timing constants for the 68k bus cycle controller.
package bus_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    EXTWAIT = 3'd2,
    ACK     = 3'd3,
    BERR    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    RGN_ROM  = 3'd0,
    RGN_RAM  = 3'd1,
    RGN_IO   = 3'd2,
    RGN_GFX  = 3'd3,
    RGN_DRAM = 3'd4,
    RGN_CAN  = 3'd5,
    RGN_NONE = 3'd6
  } region_t;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_ROM_WAIT = 0;
  localparam int unsigned DEF_RAM_WAIT = 1;
  localparam int unsigned DEF_IO_WAIT  = 2;
  localparam int unsigned DEF_GFX_WAIT = 3;
  localparam int unsigned DEF_TIMEOUT  = 255;

  function automatic logic is_self_timed(input region_t rgn);
    return (rgn == RGN_DRAM) || (rgn == RGN_CAN);
  endfunction

endpackage

// File: rtl/region_priority_encoder.sv
// Picks the winning decoder select (ROM highest, CAN lowest) and flags
// cycles where more than one select is active.
module region_priority_encoder
  import bus_ctl_pkg::*;
(
  input  logic    i_rom_sel,
  input  logic    i_ram_sel,
  input  logic    i_io_sel,
  input  logic    i_gfx_sel,
  input  logic    i_dram_sel,
  input  logic    i_can_sel,
  output region_t o_region,
  output logic    o_conflict
);

  logic [2:0] w_active_cnt;

  always_comb begin
    o_region = RGN_NONE;
    if (i_rom_sel)       o_region = RGN_ROM;
    else if (i_ram_sel)  o_region = RGN_RAM;
    else if (i_io_sel)   o_region = RGN_IO;
    else if (i_gfx_sel)  o_region = RGN_GFX;
    else if (i_dram_sel) o_region = RGN_DRAM;
    else if (i_can_sel)  o_region = RGN_CAN;
  end

  assign w_active_cnt = {2'b00, i_rom_sel} + {2'b00, i_ram_sel} + {2'b00, i_io_sel}
                      + {2'b00, i_gfx_sel} + {2'b00, i_dram_sel} + {2'b00, i_can_sel};
  assign o_conflict   = (w_active_cnt > 3'd1);

endmodule

// File: rtl/bus_cycle_controller.sv
// Sequences each 68k bus cycle: fixed wait states for on-chip regions,
// forwarded DTACK for self-timed slaves, bus error on unmapped or timeout.
module bus_cycle_controller
  import bus_ctl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
  parameter int unsigned GFX_WAIT = DEF_GFX_WAIT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic i_Clock,
  input  logic i_Reset_H,
  input  logic i_AS_L,
  input  logic i_OnChipRomSelect_H,
  input  logic i_OnChipRamSelect_H,
  input  logic i_IOSelect_H,
  input  logic i_GraphicsCS_L,
  input  logic i_DramSelect_H,
  input  logic i_CanBusSelect_H,
  input  logic i_DramDtack_L,
  input  logic i_CanBusDtack_L,
  output logic o_Dtack_L,
  output logic o_BErr_L,
  output logic o_Timeout_H,
  output logic o_Conflict_H
);

  localparam logic [CNT_W-1:0] LD_ROM     = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] LD_RAM     = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] LD_IO      = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] LD_GFX     = CNT_W'(GFX_WAIT);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           r_state,  w_state_next;
  region_t          r_region, w_region;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next, w_wait_load;
  logic             w_conflict, w_ext_dtack_l;
  logic             r_dtack_l, r_berr_l, r_timeout, r_conflict;
  logic             w_dtack_l_next, w_berr_l_next, w_timeout_next, w_conflict_next;

  region_priority_encoder u_prio (
    .i_rom_sel  (i_OnChipRomSelect_H),
    .i_ram_sel  (i_OnChipRamSelect_H),
    .i_io_sel   (i_IOSelect_H),
    .i_gfx_sel  (!i_GraphicsCS_L),
    .i_dram_sel (i_DramSelect_H),
    .i_can_sel  (i_CanBusSelect_H),
    .o_region   (w_region),
    .o_conflict (w_conflict)
  );

  always_comb begin
    w_wait_load = LD_TIMEOUT;
    case (w_region)
      RGN_ROM: w_wait_load = LD_ROM;
      RGN_RAM: w_wait_load = LD_RAM;
      RGN_IO:  w_wait_load = LD_IO;
      RGN_GFX: w_wait_load = LD_GFX;
      default: w_wait_load = LD_TIMEOUT;
    endcase
  end

  // Only the slave latched at cycle start may acknowledge.
  assign w_ext_dtack_l = (r_region == RGN_DRAM) ? i_DramDtack_L : i_CanBusDtack_L;

  always_ff @(posedge i_Clock or posedge i_Reset_H) begin
    if (i_Reset_H) begin
      r_state    <= IDLE;
      r_region   <= RGN_NONE;
      r_cnt      <= '0;
      r_dtack_l  <= 1'b1;
      r_berr_l   <= 1'b1;
      r_timeout  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_dtack_l  <= w_dtack_l_next;
      r_berr_l   <= w_berr_l_next;
      r_timeout  <= w_timeout_next;
      r_conflict <= w_conflict_next;
      if (r_state == IDLE && !i_AS_L) r_region <= w_region;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (!i_AS_L) begin
          w_cnt_next = w_wait_load;
          if (w_region == RGN_NONE)      w_state_next = BERR;
          else if (is_self_timed(w_region)) w_state_next = EXTWAIT;
          else                           w_state_next = COUNT;
        end
      end
      COUNT: begin
        if (i_AS_L)            w_state_next = IDLE;
        else if (r_cnt == '0)  w_state_next = ACK;
        else                   w_cnt_next = r_cnt - 1'b1;
      end
      EXTWAIT: begin
        if (i_AS_L)              w_state_next = IDLE;
        else if (!w_ext_dtack_l) w_state_next = ACK;
        else if (r_cnt == '0)    w_state_next = BERR;
        else                     w_cnt_next = r_cnt - 1'b1;
      end
      ACK, BERR: begin
        if (i_AS_L) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // An unmapped cycle spends its first edge in BERR before BErr_L drops.
  always_comb begin
    w_dtack_l_next  = !(w_state_next == ACK);
    w_berr_l_next   = !((w_state_next == BERR) && (r_state != IDLE));
    w_timeout_next  = (r_state == EXTWAIT) && (w_state_next == BERR);
    w_conflict_next = (r_state == IDLE) && !i_AS_L && w_conflict;
  end

  assign o_Dtack_L    = r_dtack_l;
  assign o_BErr_L     = r_berr_l;
  assign o_Timeout_H  = r_timeout;
  assign o_Conflict_H = r_conflict;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller: vector table plus multi-cycle sequences.
module tb_bus_cycle_controller;

  logic clk = 1'b0;
  logic rst;
  logic as_l, rom, ram, io, gfx_l, dram, can, dram_dtk, can_dtk;
  logic dtack_l, berr_l, timeout_h, conflict_h;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic as_l, rom, ram, io, gfx_l, dram, can;
    logic e_dtk, e_berr, e_to, e_conf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_cycle_controller #(.TIMEOUT(15)) dut (
    .i_Clock             (clk),
    .i_Reset_H           (rst),
    .i_AS_L              (as_l),
    .i_OnChipRomSelect_H (rom),
    .i_OnChipRamSelect_H (ram),
    .i_IOSelect_H        (io),
    .i_GraphicsCS_L      (gfx_l),
    .i_DramSelect_H      (dram),
    .i_CanBusSelect_H    (can),
    .i_DramDtack_L       (dram_dtk),
    .i_CanBusDtack_L     (can_dtk),
    .o_Dtack_L           (dtack_l),
    .o_BErr_L            (berr_l),
    .o_Timeout_H         (timeout_h),
    .o_Conflict_H        (conflict_h)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_dtk, input logic e_berr,
                         input logic e_to, input logic e_conf);
    chk({tag, " Dtack_L"}, dtack_l, e_dtk);
    chk({tag, " BErr_L"}, berr_l, e_berr);
    chk({tag, " Timeout_H"}, timeout_h, e_to);
    chk({tag, " Conflict_H"}, conflict_h, e_conf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic a, input logic r0, input logic r1, input logic r2,
                         input logic g, input logic d, input logic c);
    as_l = a; rom = r0; ram = r1; io = r2; gfx_l = g; dram = d; can = c;
  endtask

  function automatic vec_t mk(input logic a, input logic r0, input logic r1, input logic r2,
                              input logic g, input logic d, input logic c,
                              input logic ed, input logic eb, input logic et, input logic ec);
    vec_t v;
    v.as_l = a; v.rom = r0; v.ram = r1; v.io = r2; v.gfx_l = g; v.dram = d; v.can = c;
    v.e_dtk = ed; v.e_berr = eb; v.e_to = et; v.e_conf = ec;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    set_sel(1, 0, 0, 0, 1, 0, 0);
    dram_dtk = 1'b1;
    can_dtk  = 1'b1;
    #12;
    chk_all("reset", 1, 1, 0, 0);
    $display("txn reset: Dtack_L=%b BErr_L=%b", dtack_l, berr_l);
    rst = 1'b0;
    tick();

    // as  rom ram io gfxL dram can | dtk berr to conf
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));   // idle
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));   // ROM E0
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));   // ACK, selects dropped
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));   // release
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));   // IO E0
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));   // E0+3
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 1));   // RAM+IO conflict
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0));   // RAM timing
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));   // unmapped E0
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0));   // RAM E0
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0));   // abort in COUNT
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));   // fresh ROM cycle
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));   // GFX E0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // E0+4
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));

    foreach (vecs[i]) begin
      set_sel(vecs[i].as_l, vecs[i].rom, vecs[i].ram, vecs[i].io,
              vecs[i].gfx_l, vecs[i].dram, vecs[i].can);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_dtk, vecs[i].e_berr, vecs[i].e_to, vecs[i].e_conf);
      $display("txn vec%0d: AS_L=%b -> Dtack_L=%b BErr_L=%b Timeout_H=%b Conflict_H=%b",
               i, vecs[i].as_l, dtack_l, berr_l, timeout_h, conflict_h);
    end

    // DRAM: slave acks on E0+5; CAN's DTACK held low must be ignored meanwhile.
    set_sel(0, 0, 0, 0, 1, 1, 0);
    can_dtk = 1'b0;
    tick();
    chk_all("dram E0", 1, 1, 0, 0);
    set_sel(0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("dram E0+%0d", k), 1, 1, 0, 0);
    end
    dram_dtk = 1'b0;
    tick();
    chk_all("dram E0+5", 0, 1, 0, 0);
    dram_dtk = 1'b1;
    can_dtk  = 1'b1;
    as_l = 1'b1;
    tick();
    chk_all("dram release", 1, 1, 0, 0);
    $display("txn dram: acked at E0+5");

    // CAN timeout with TIMEOUT=15; DRAM's DTACK held low must be ignored.
    set_sel(0, 0, 0, 0, 1, 0, 1);
    dram_dtk = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      tick();
      chk_all($sformatf("can E0+%0d", k), 1, 1, 0, 0);
    end
    tick();
    chk_all("can E0+16", 1, 0, 1, 0);
    tick();
    chk_all("can E0+17", 1, 0, 0, 0);
    as_l = 1'b1;
    dram_dtk = 1'b1;
    tick();
    chk_all("can release", 1, 1, 0, 0);
    $display("txn can: timeout bus error at E0+16");

    // Asynchronous reset while in ACK.
    set_sel(0, 1, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk("rst pre Dtack_L", dtack_l, 1'b0);
    rst = 1'b1;
    #2;
    chk("rst async Dtack_L", dtack_l, 1'b1);
    chk("rst async BErr_L", berr_l, 1'b1);
    #1;
    rst = 1'b0;
    set_sel(1, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("post rst", 1, 1, 0, 0);
    $display("txn reset-in-ack: Dtack_L=%b", dtack_l);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
